kernal33_seq: RTL

Frame sequencer for the 3x3 convolution datapath `kernal33`. It accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 window register. It drives `kernal33`'s `im1`/`im2`/`im3`/`k1`/`k2`/`k3` inputs, captures its 32-bit `result` for every valid window, and emits the results as a handshaked stream. The bench and top level instantiate `kernal33` alongside this block and wire `result` back to `kres`.

---
 rtl/kernal33_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/kernal33_seq.sv
// rtl/kernal33_seq.sv - raster-order frame sequencer feeding the kernal33 3x3 datapath
// Holds two line buffers, a 3x3 window and the coefficient rows; captures kres as a handshaked stream.
module kernal33_seq #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_addr,
  input  logic [PIX_W-1:0]   cfg_data,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIX_W-1:0]   pix_data,
  output logic [3*PIX_W-1:0] im1,
  output logic [3*PIX_W-1:0] im2,
  output logic [3*PIX_W-1:0] im3,
  output logic [3*PIX_W-1:0] k1,
  output logic [3*PIX_W-1:0] k2,
  output logic [3*PIX_W-1:0] k3,
  input  logic [31:0]        kres,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int XW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 2) ? $clog2(IMG_H + 1) : 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0]      col;
  logic [YW-1:0]      row;
  logic [PIX_W-1:0]   coef    [0:8];
  logic [PIX_W-1:0]   lb_top  [0:IMG_W-1];
  logic [PIX_W-1:0]   lb_mid  [0:IMG_W-1];
  logic [3*PIX_W-1:0] win_top, win_mid, win_bot;
  logic               win_pend, win_last;

  logic out_free, accept, capture, win_done;
  logic at_row_end, at_last_row;

  assign out_free    = !out_valid || out_ready;
  assign pix_ready   = (state == S_RUN) && (!win_pend || out_free);
  assign accept      = pix_ready && pix_valid;
  assign capture     = win_pend && out_free;
  assign at_row_end  = (col == XW'(IMG_W - 1));
  assign at_last_row = (row == YW'(IMG_H - 1));
  // Columns 0 and 1 of a row still hold the previous row's tail, so only c>=2 windows count.
  assign win_done    = accept && (row >= YW'(2)) && (col >= XW'(2));

  assign im1 = win_top;
  assign im2 = win_mid;
  assign im3 = win_bot;
  assign k1  = {coef[0], coef[1], coef[2]};
  assign k2  = {coef[3], coef[4], coef[5]};
  assign k3  = {coef[6], coef[7], coef[8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (accept && at_row_end && at_last_row) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_valid && out_ready && out_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (state == S_IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (at_row_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) coef[i] <= '0;
    end else if (state == S_IDLE && cfg_we) begin
      for (int i = 0; i < 9; i++) begin
        if (cfg_addr == 4'(i)) coef[i] <= cfg_data;
      end
    end
  end

  // Rolling pair of line buffers: lb_mid holds row r-1, lb_top row r-2 at each column.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else if (accept) begin
      win_top <= {win_top[2*PIX_W-1:0], lb_top[col]};
      win_mid <= {win_mid[2*PIX_W-1:0], lb_mid[col]};
      win_bot <= {win_bot[2*PIX_W-1:0], pix_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pend <= 1'b0;
      win_last <= 1'b0;
    end else if (win_done) begin
      win_pend <= 1'b1;
      win_last <= at_row_end && at_last_row;
    end else if (capture) begin
      win_pend <= 1'b0;
    end
  end

  // kres is sampled before the window shifts on the same edge, so it matches the pending window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= kres;
      out_last  <= win_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
